// File: rtl/key_pkg.sv
// Shared types and helpers for the key debounce bank.
// Optional auto-repeat is selected with the KEY_AUTOREPEAT_EN macro.
package key_pkg;

  typedef enum logic [1:0] {
    StUp,
    StDnPend,
    StDn,
    StUpPend
  } key_state_e;

  localparam int unsigned MsPerSec = 1000;
  localparam int unsigned StateW   = 2;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
    return clk_hz / MsPerSec * ms;
  endfunction

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM, hold counter and strobes.
// Defining KEY_AUTOREPEAT_EN adds periodic key_press re-pulses after a long press.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned LONG_CYCLES   = 20,
`ifdef KEY_AUTOREPEAT_EN
  parameter int unsigned REPEAT_CYCLES = 5,
`endif
  parameter int unsigned ACTIVE_LOW    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned CntW  = cnt_width(DB_CYCLES);
  localparam int unsigned HcntW = cnt_width(LONG_CYCLES);

  logic       sync1_q, sync_q;
  key_state_e state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [HcntW-1:0] hcnt_q, hcnt_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic long_q, long_d;

  // Normalised so that 1 always means pressed; reset loads the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      sync1_q <= key_in ^ (ACTIVE_LOW != 0);
      sync_q  <= sync1_q;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RcntW = cnt_width(REPEAT_CYCLES);
  logic [RcntW-1:0] rcnt_q, rcnt_d;

  always_ff @(posedge clk) begin
    if (rst) rcnt_q <= '0;
    else     rcnt_q <= rcnt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StUp;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    rcnt_d    = '0;
`endif
    unique case (state_q)
      StUp: begin
        if (sync_q) begin
          state_d = StDnPend;
          cnt_d   = CntW'(1);
        end
      end
      StDnPend: begin
        if (!sync_q) begin
          state_d = StUp;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(DB_CYCLES - 1)) begin
          state_d = StDn;
          cnt_d   = '0;
          hcnt_d  = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDn: begin
        // Saturating at LONG_CYCLES makes the long strobe fire once per press.
        if (hcnt_q != HcntW'(LONG_CYCLES)) hcnt_d = hcnt_q + HcntW'(1);
        if (hcnt_q == HcntW'(LONG_CYCLES - 2)) long_d = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
        if (hcnt_q >= HcntW'(LONG_CYCLES - 1)) begin
          if (rcnt_q == RcntW'(REPEAT_CYCLES - 1)) begin
            press_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RcntW'(1);
          end
        end
`endif
        if (!sync_q) begin
          state_d = StUpPend;
          cnt_d   = CntW'(1);
        end
      end
      StUpPend: begin
        if (sync_q) begin
          state_d = StDn;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(DB_CYCLES - 1)) begin
          state_d   = StUp;
          cnt_d     = '0;
          hcnt_d    = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StUp;
        cnt_d   = '0;
      end
    endcase
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule

// File: rtl/key_debounce_bank.sv
// N_KEYS independent push-button conditioners (level, press/release/long strobes).
// Defining KEY_AUTOREPEAT_EN enables key_press auto-repeat after a long press.
module key_debounce_bank
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS      = 4,
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 200,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  localparam int unsigned DB_CYCLES     = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned LONG_CYCLES   = ms_to_cycles(CLK_HZ, LONG_MS);
  localparam int unsigned REPEAT_CYCLES = ms_to_cycles(CLK_HZ, REPEAT_MS);

  // Counter compares assume at least two debounce cycles and a longer hold time.
  if (DB_CYCLES < 2 || LONG_CYCLES <= DB_CYCLES || REPEAT_CYCLES < 1) begin : g_cfg_err
    $error("key_debounce_bank: invalid timing parameters");
  end

  for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_chan
    key_debounce_chan #(
      .DB_CYCLES    (DB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
`ifdef KEY_AUTOREPEAT_EN
      .REPEAT_CYCLES(REPEAT_CYCLES),
`endif
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .key_in     (key_in[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_bank.sv
// Scoreboard bench for key_debounce_bank: a run-length reference model pushes the
// expected outputs of every edge; a negedge monitor pops and compares them.
module tb_key_debounce_bank;

  localparam int N    = 2;
  localparam int DB   = 4;
  localparam int LNG  = 20;
  localparam int RPT  = 5;
  localparam int ALOW = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] key_in;
  logic [N-1:0] key_level, key_press, key_release, key_long;

  key_debounce_bank #(
    .N_KEYS     (N),
    .CLK_HZ     (1000),
    .DEBOUNCE_MS(4),
    .LONG_MS    (20),
    .REPEAT_MS  (5),
    .ACTIVE_LOW (ALOW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   base   = 0;

  // Reference model state: pipeline of two samples, debounced level, length of
  // the current run of samples disagreeing with it, and cycles spent held.
  bit m_p1[N], m_p2[N], m_lvl[N];
  int m_run[N], m_held[N], m_rpt[N];

  int last_press[N], last_rel[N], last_long[N];
  int n_press[N], n_rel[N], n_long[N];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    bit   s, in_dn;
    e = '0;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_p1[i] = 1'b0; m_p2[i] = 1'b0; m_lvl[i] = 1'b0;
        m_run[i] = 0; m_held[i] = 0; m_rpt[i] = 0;
      end else begin
        s     = m_p2[i];
        in_dn = m_lvl[i] && (m_run[i] == 0);
        if (in_dn) begin
          if (m_held[i] == LNG - 2) e.lng[i] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
          if (m_held[i] >= LNG - 1) begin
            if (m_rpt[i] == RPT - 1) begin
              e.prs[i] = 1'b1;
              m_rpt[i] = 0;
            end else begin
              m_rpt[i]++;
            end
          end else begin
            m_rpt[i] = 0;
          end
`endif
          if (m_held[i] < LNG) m_held[i]++;
        end else begin
          m_rpt[i] = 0;
        end
        if (s != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_lvl[i] = !m_lvl[i];
            m_run[i] = 0;
            if (m_lvl[i]) begin
              e.prs[i] = 1'b1;
            end else begin
              e.rel[i]  = 1'b1;
              m_held[i] = 0;
            end
          end
        end else begin
          m_run[i] = 0;
        end
        m_p2[i] = m_p1[i];
        m_p1[i] = key_in[i] ^ (ALOW != 0);
      end
      e.lvl[i] = m_lvl[i];
    end
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("key_level", 32'(key_level), 32'(e.lvl));
      chk("key_press", 32'(key_press), 32'(e.prs));
      chk("key_release", 32'(key_release), 32'(e.rel));
      chk("key_long", 32'(key_long), 32'(e.lng));
    end
    for (int i = 0; i < N; i++) begin
      if (key_press[i] === 1'b1)   begin last_press[i] = cyc; n_press[i]++; end
      if (key_release[i] === 1'b1) begin last_rel[i] = cyc;   n_rel[i]++;   end
      if (key_long[i] === 1'b1)    begin last_long[i] = cyc;  n_long[i]++;  end
    end
  end

  // Returns just after edge base+k, where pin changes count as "at edge k".
  task automatic at_edge(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int np0, np1, nr0, nl0, hold[N], r;
    for (int i = 0; i < N; i++) begin
      last_press[i] = -1; last_rel[i] = -1; last_long[i] = -1;
      n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0;
    end
    rst    = 1'b1;
    key_in = '1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_level", 32'(key_level), 32'd0);
    repeat (5) begin @(posedge clk); #1; end

    // Long press on key 0, DB-1 cycle glitch on key 1, bouncy release on key 0.
    base = cyc;
    np0 = n_press[0]; np1 = n_press[1]; nr0 = n_rel[0]; nl0 = n_long[0];
    at_edge(10); key_in = 2'b00;
    at_edge(13); key_in[1] = 1'b1;
    at_edge(40);
    chk("s1_press_edge", last_press[0] - base, 16);
    chk("s1_long_edge", last_long[0] - base, 35);
    chk("s1_glitch_no_press", n_press[1] - np1, 0);
    chk("s1_level", 32'(key_level), 32'd1);
    at_edge(46); key_in[0] = 1'b1;
    at_edge(47); key_in[0] = 1'b0;
    at_edge(48); key_in[0] = 1'b1;
    at_edge(49); key_in[0] = 1'b0;
    at_edge(50); key_in[0] = 1'b1;
    at_edge(62);
    chk("s1_release_edge", last_rel[0] - base, 56);
    chk("s1_single_press", n_press[0] - np0, 1);
    chk("s1_single_release", n_rel[0] - nr0, 1);
    chk("s1_single_long", n_long[0] - nl0, 1);

    // Both keys pressed together, only key 1 released.
    at_edge(70);
    base = cyc;
    nr0  = n_rel[0];
    at_edge(10); key_in = 2'b00;
    at_edge(30); key_in[1] = 1'b1;
    at_edge(45);
    chk("s2_press0_edge", last_press[0] - base, 16);
    chk("s2_press1_edge", last_press[1] - base, 16);
    chk("s2_release1_edge", last_rel[1] - base, 36);
    chk("s2_no_release0", n_rel[0] - nr0, 0);
    at_edge(46); key_in[0] = 1'b1;

    // Reset while key 0 is held: no release, fresh press after reset.
    at_edge(70);
    base = cyc;
    nr0  = n_rel[0];
    at_edge(10); key_in[0] = 1'b0;
    at_edge(20);
    chk("s3_level_before_rst", 32'(key_level[0]), 32'd1);
    rst = 1'b1;
    at_edge(21);
    chk("s3_level_after_rst", 32'(key_level), 32'd0);
    at_edge(22); rst = 1'b0;
    at_edge(34);
    chk("s3_repress_edge", last_press[0] - base, 28);
    chk("s3_no_release", n_rel[0] - nr0, 0);
    key_in[0] = 1'b1;
    at_edge(45);

    // Random bursts: bounces, near-threshold holds, long holds, sparse resets.
    for (int i = 0; i < N; i++) hold[i] = 1;
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          key_in[i] = ~key_in[i];
          r = int'($urandom_range(0, 9));
          if (r < 4)      hold[i] = int'($urandom_range(1, 3));
          else if (r < 7) hold[i] = int'($urandom_range(DB - 1, DB + 2));
          else            hold[i] = int'($urandom_range(LNG - 2, LNG + 12));
        end else begin
          hold[i]--;
        end
      end
      rst = ($urandom_range(0, 499) == 0);
      @(posedge clk);
      #1;
    end
    rst    = 1'b0;
    key_in = '1;
    repeat (40) begin @(posedge clk); #1; end
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
